// File: rtl/wb_vram_dp.sv
// Dual-port video RAM: Wishbone-classic CPU port, 1-cycle VGA scan port, hardware clear engine.
// Optional macro VRAM_BYTE_SEL_EN enables per-lane CPU writes via sel_i; otherwise every write is full-word.
module wb_vram_dp #(
  parameter int DW    = 32,
  parameter int AW    = 11,
  parameter int DEPTH = 1200
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cyc_i,
  input  logic            stb_i,
  input  logic            we_i,
  input  logic [31:0]     adr_i,
  input  logic [DW/8-1:0] sel_i,
  input  logic [DW-1:0]   dat_i,
  output logic [DW-1:0]   dat_o,
  output logic            ack_o,
  output logic            err_o,
  input  logic [AW-1:0]   vga_addr,
  output logic [DW-1:0]   vga_dout,
  input  logic            clr_req,
  input  logic [DW-1:0]   clr_val,
  output logic            clr_busy,
  output logic            clr_done
);

  localparam int NB = DW / 8;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] LAST_L  = (AW+1)'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, RD_WAIT, ACK, CLEAR} state_t;

  state_t          state;
  logic [DW-1:0]   mem [DEPTH];
  logic [DW-1:0]   rd_word;
  logic [DW-1:0]   fill_val;
  logic [AW-1:0]   clr_cnt;
  logic            pending;

  logic [AW-1:0]   bus_idx;
  logic            req;
  logic            bus_in_range;
  logic            bus_hit;
  logic            cpu_we;
  logic            clr_we;
  logic            mem_we;
  logic [AW-1:0]   mem_adr;
  logic [DW-1:0]   mem_wdat;
  logic [NB-1:0]   lane_en;
  logic            unused;

  assign bus_idx      = adr_i[AW+1:2];
  assign req          = cyc_i & stb_i;
  assign bus_in_range = ({1'b0, bus_idx} < DEPTH_L);
  assign bus_hit      = (state == IDLE) & req;
  assign cpu_we       = bus_hit & we_i & bus_in_range;
  assign clr_we       = (state == CLEAR);
  // The shared write port is blocked while reset is held so an aborted access cannot land.
  assign mem_we       = (cpu_we | clr_we) & rst_n;
  assign mem_adr      = clr_we ? clr_cnt : bus_idx;
  assign mem_wdat     = clr_we ? fill_val : dat_i;

`ifdef VRAM_BYTE_SEL_EN
  assign lane_en = clr_we ? {NB{1'b1}} : sel_i;
  assign unused  = ^{adr_i[31:AW+2], adr_i[1:0]};
`else
  assign lane_en = {NB{1'b1}};
  assign unused  = ^{adr_i[31:AW+2], adr_i[1:0], sel_i};
`endif

  // Array and CPU read register carry no reset so contents survive a mid-clear reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NB; i++) begin
        if (lane_en[i]) mem[mem_adr][8*i +: 8] <= mem_wdat[8*i +: 8];
      end
    end
    if (bus_hit && !we_i && bus_in_range) rd_word <= mem[bus_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ack_o    <= 1'b0;
      err_o    <= 1'b0;
      dat_o    <= '0;
      vga_dout <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
      clr_cnt  <= '0;
      pending  <= 1'b0;
      fill_val <= '0;
    end else begin
      clr_done <= 1'b0;
      if (clr_req && !clr_busy) begin
        pending  <= 1'b1;
        fill_val <= clr_val;
      end

      case (state)
        IDLE: begin
          if (req) begin
            if (!bus_in_range) begin
              err_o <= 1'b1;
              state <= ACK;
            end else if (we_i) begin
              ack_o <= 1'b1;
              state <= ACK;
            end else begin
              state <= RD_WAIT;
            end
          end else if (pending) begin
            state    <= CLEAR;
            clr_busy <= 1'b1;
            clr_cnt  <= '0;
          end
        end
        RD_WAIT: begin
          dat_o <= rd_word;
          ack_o <= 1'b1;
          state <= ACK;
        end
        ACK: begin
          ack_o <= 1'b0;
          err_o <= 1'b0;
          state <= IDLE;
        end
        CLEAR: begin
          if ({1'b0, clr_cnt} == LAST_L) begin
            clr_busy <= 1'b0;
            clr_done <= 1'b1;
            pending  <= 1'b0;
            state    <= IDLE;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if ({1'b0, vga_addr} < DEPTH_L) vga_dout <= mem[vga_addr];
      else                            vga_dout <= '0;
    end
  end

endmodule

// File: tb/tb_wb_vram_dp.sv
// Randomised scoreboard bench for wb_vram_dp against an array-level model of the VRAM.
module tb_wb_vram_dp;
  localparam int DW = 32, AW = 11, DEPTH = 1200;

  logic          clk, rst_n;
  logic          cyc_i, stb_i, we_i;
  logic [31:0]   adr_i;
  logic [3:0]    sel_i;
  logic [DW-1:0] dat_i, dat_o;
  logic          ack_o, err_o;
  logic [AW-1:0] vga_addr;
  logic [DW-1:0] vga_dout;
  logic          clr_req;
  logic [DW-1:0] clr_val;
  logic          clr_busy, clr_done;

  wb_vram_dp #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
    .adr_i(adr_i), .sel_i(sel_i), .dat_i(dat_i), .dat_o(dat_o),
    .ack_o(ack_o), .err_o(err_o), .vga_addr(vga_addr), .vga_dout(vga_dout),
    .clr_req(clr_req), .clr_val(clr_val), .clr_busy(clr_busy), .clr_done(clr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt++;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  // Reference model: plain array of words plus a "contents known" flag.
  logic [DW-1:0] model [DEPTH];
  bit            known [DEPTH];
  logic [DW-1:0] last_dat;
  bit            last_known;

  typedef struct {
    bit            is_err;
    bit            chk_dat;
    logic [DW-1:0] dat;
    int            exp_edge;
    int            need_done;
  } exp_t;
  typedef struct {
    logic [DW-1:0] dat;
    int            edge_n;
  } vexp_t;

  exp_t  sbq[$];
  vexp_t vq[$];
  exp_t  mon_e;
  vexp_t mon_v;
  int    busy_run = 0, done_cnt = 0;

  always @(negedge clk) begin
    if (rst_n && (ack_o || err_o)) begin
      if (sbq.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL spurious_ack: got ack=%0b err=%0b expected no response", ack_o, err_o);
      end else begin
        mon_e = sbq.pop_front();
        check("ack_err", {62'd0, ack_o, err_o}, mon_e.is_err ? 64'd1 : 64'd2);
        if (mon_e.chk_dat)        check("dat_o", dat_o, mon_e.dat);
        if (mon_e.exp_edge >= 0)  check("ack_latency", cyc_cnt, mon_e.exp_edge);
        if (mon_e.need_done >= 0) begin
          check("stall_until_done", (done_cnt >= mon_e.need_done) ? 1 : 0, 1);
          check("busy_at_ack", clr_busy, 0);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (vq.size() > 0 && vq[0].edge_n == cyc_cnt) begin
      mon_v = vq.pop_front();
      check("vga_dout", vga_dout, mon_v.dat);
    end
  end

  always @(negedge clk) begin
    if (!rst_n) busy_run = 0;
    else begin
      if (clr_done) begin
        done_cnt++;
        check("clr_busy_len", busy_run, DEPTH);
        check("done_busy_excl", clr_busy, 0);
        busy_run = 0;
      end
      if (clr_busy) busy_run++;
    end
  end

  // Called just after a rising edge; returns just after a rising edge with the bus idle again.
  task automatic wb(bit we, logic [31:0] adr, logic [DW-1:0] d, logic [3:0] sel, bit stalled);
    exp_t e;
    int   idx;
    bit   got;
    idx = int'(adr[AW+1:2]);
    e.need_done = stalled ? done_cnt + 1 : -1;
    if (idx >= DEPTH) begin
      e.is_err = 1; e.chk_dat = last_known; e.dat = last_dat;
      e.exp_edge = stalled ? -1 : cyc_cnt + 1;
    end else if (we) begin
      e.is_err = 0; e.chk_dat = 0; e.dat = '0;
      e.exp_edge = stalled ? -1 : cyc_cnt + 1;
`ifdef VRAM_BYTE_SEL_EN
      for (int b = 0; b < 4; b++) if (sel[b]) model[idx][8*b +: 8] = d[8*b +: 8];
      if (sel == 4'hF) known[idx] = 1;
`else
      model[idx] = d;
      known[idx] = 1;
`endif
    end else begin
      e.is_err = 0; e.chk_dat = known[idx]; e.dat = model[idx];
      e.exp_edge = stalled ? -1 : cyc_cnt + 2;
      last_known = known[idx]; last_dat = model[idx];
    end
    sbq.push_back(e);
    cyc_i = 1; stb_i = 1; we_i = we; adr_i = adr; dat_i = d; sel_i = sel;
    got = 0;
    for (int t = 0; t < 3000 && !got; t++) begin
      @(posedge clk); #1;
      if (ack_o || err_o) got = 1;
    end
    cyc_i = 0; stb_i = 0; we_i = 0;
    if (!got) begin
      n_chk++; n_fail++;
      $display("FAIL wb_timeout: got no ack for adr 0x%0h expected ack within 3000 cycles", adr);
      void'(sbq.pop_back());
    end
    @(posedge clk); #1;
  endtask

  task automatic vga_probe(int a);
    vexp_t v;
    vga_addr = AW'(a);
    if (a >= DEPTH || known[a]) begin
      v.dat = (a >= DEPTH) ? '0 : model[a];
      v.edge_n = cyc_cnt + 1;
      vq.push_back(v);
    end
    @(posedge clk); #1;
  endtask

  task automatic clear_start(logic [DW-1:0] v, bit upd);
    clr_val = v; clr_req = 1;
    @(posedge clk); #1;
    clr_req = 0;
    if (upd) for (int i = 0; i < DEPTH; i++) begin model[i] = v; known[i] = 1; end
  endtask

  task automatic wait_done();
    int d0;
    d0 = done_cnt;
    for (int t = 0; t < 3000 && done_cnt == d0; t++) begin
      @(posedge clk); #1;
    end
    if (done_cnt == d0) begin
      n_chk++; n_fail++;
      $display("FAIL clr_timeout: got no clr_done expected one within 3000 cycles");
    end
  endtask

  initial begin
    #5_000_000;
    n_fail++;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    int d0, idx;
    for (int i = 0; i < DEPTH; i++) known[i] = 0;
    rst_n = 0; cyc_i = 0; stb_i = 0; we_i = 0; adr_i = '0; sel_i = '0; dat_i = '0;
    vga_addr = '0; clr_req = 0; clr_val = '0;
    last_dat = '0; last_known = 1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", ack_o, 0);
    check("rst_err", err_o, 0);
    check("rst_dat", dat_o, 0);
    check("rst_vga", vga_dout, 0);
    check("rst_busy", clr_busy, 0);
    check("rst_done", clr_done, 0);
    rst_n = 1;
    @(posedge clk); #1;

    // Basic write/read and VGA view of the same word.
    wb(1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    wb(0, 32'h10, '0, 4'hF, 0);
    vga_probe(4);

    // Out-of-range index: error, no change.
    wb(1, 1199*4, 32'h5A5A1199, 4'hF, 0);
    wb(0, 32'h12C0, '0, 4'hF, 0);
    wb(1, 32'h12C0, 32'hFFFFFFFF, 4'hF, 0);
    wb(0, 1199*4, '0, 4'hF, 0);

    // Full clear and spot checks on both ports.
    clear_start(32'h00200020, 1);
    wait_done();
    wb(0, 0, '0, 4'hF, 0);
    wb(0, 600*4, '0, 4'hF, 0);
    wb(0, 1199*4, '0, 4'hF, 0);
    vga_probe(0); vga_probe(1199); vga_probe(1200); vga_probe(2047);

    // Write issued during a clear is stalled, then lands over the fill value.
    clear_start(32'hCAFE0000, 1);
    repeat (5) @(posedge clk);
    #1;
    wb(1, 77*4, 32'h12345678, 4'hF, 1);
    wb(0, 77*4, '0, 4'hF, 0);
    wb(0, 78*4, '0, 4'hF, 0);

    // Byte-lane write behaviour.
    wb(1, 300*4, 32'h11223344, 4'hF, 0);
    wb(1, 300*4, 32'hAABBCCDD, 4'b0101, 0);
    wb(0, 300*4, '0, 4'hF, 0);
    wb(1, 300*4 + 2, 32'h99999999, 4'b0000, 0);
    wb(0, 300*4, '0, 4'hF, 0);

    // Randomised traffic including out-of-range indices and unaligned byte offsets.
    for (int n = 0; n < 300; n++) begin
      idx = $urandom_range(0, 1299);
      wb($urandom_range(0, 1), 32'(idx * 4 + $urandom_range(0, 3)), $urandom, 4'($urandom), 0);
      vga_probe($urandom_range(0, 1299));
    end

    // Reset in the middle of a clear: partial fill is kept, no done pulse.
    wb(1, 1100*4, 32'h0BADF00D, 4'hF, 0);
    wb(1, 50*4, 32'h11111111, 4'hF, 0);
    clear_start(32'h77777777, 0);
    for (int t = 0; t < 50 && !clr_busy; t++) begin
      @(posedge clk); #1;
    end
    check("clr_started", clr_busy, 1);
    repeat (100) @(posedge clk);
    #2;
    d0 = done_cnt;
    rst_n = 0;
    #1;
    check("rst_mid_busy", clr_busy, 0);
    check("rst_mid_done", clr_done, 0);
    for (int i = 0; i < 110; i++) begin
      if (i < 90) begin model[i] = 32'h77777777; known[i] = 1; end
      else known[i] = 0;
    end
    last_dat = '0; last_known = 1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1;
    repeat (1300) @(posedge clk);
    #1;
    check("no_done_after_rst", done_cnt, d0);
    check("idle_after_rst", clr_busy, 0);
    wb(0, 50*4, '0, 4'hF, 0);
    wb(0, 1100*4, '0, 4'hF, 0);
    vga_probe(50); vga_probe(1100);
    repeat (3) @(posedge clk);
    #1;

    check("sb_drained", sbq.size(), 0);
    check("vga_drained", vq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
